// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// sign fix-up in a final cycle, results held in HI/LO until the next completion.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  typedef struct packed {
    logic             is_div;
    logic             is_sgn;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_abs;
  } req_t;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  req_t               req_q, req_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               busy_q, done_q, dbz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_r, div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    abs_a = (op[0] && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    abs_b = (op[0] && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    req_d.is_div = op[1];
    req_d.is_sgn = op[0];
    req_d.sa     = op[0] & operand_a[WIDTH-1];
    req_d.sb     = op[0] & operand_b[WIDTH-1];
    req_d.a_raw  = operand_a;
    req_d.b_abs  = abs_b;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}; both start as {0, |a|}
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, req_q.b_abs} : '0);
    div_r   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge  = div_r >= {1'b0, req_q.b_abs};
    div_rem = div_ge ? (div_r - {1'b0, req_q.b_abs}) : div_r;
    if (req_q.is_div) acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
    else              acc_d = {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    prod_fix = (req_q.sa ^ req_q.sb) ? -acc_q : acc_q;
    quo_fix  = (req_q.sa ^ req_q.sb) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = req_q.sa ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          req_q   <= req_d;
          acc_q   <= {{WIDTH{1'b0}}, abs_a};
          cnt_q   <= '0;
          state_q <= S_CALC;
        end
        S_CALC: begin
          busy_q <= 1'b1;
          acc_q  <= acc_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
          if (req_q.is_div && req_q.b_abs == '0) begin
            dbz_q <= 1'b1;
            hi_q  <= req_q.a_raw;
            lo_q  <= '1;
          end else if (req_q.is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand sequences for handshake/reset
// corners, and random ops against a 64-bit arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] operand_a = '0, operand_b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] hi, lo;
    logic         dbz;
  } vec_t;

  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, b,
                                output logic [W-1:0] h, l, output logic z);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z = 1'b0;
    h = '0;
    l = '0;
    case (o)
      2'd0: begin p = {32'h0, a} * {32'h0, b}; h = p[63:32]; l = p[31:0]; end
      2'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == 0) begin
          h = a; l = '1; z = 1'b1;
        end else if (o == 2'd2) begin
          l = a / b; h = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          l = q[31:0]; h = r[31:0];
        end
      end
    endcase
  endfunction

  task automatic check(input string nm, input logic ok, input logic [W-1:0] act_h, act_l,
                       input logic [W-1:0] exp_h, exp_l);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got hi=%08h lo=%08h busy=%b done=%b dbz=%b, want hi=%08h lo=%08h",
               nm, act_h, act_l, busy, done, div_by_zero, exp_h, exp_l);
    end
  endtask

  // drive a request so it is sampled at the next edge (E0), then scramble inputs
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, b);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom_range(0, 3));
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  // walk E1..E(W+1): busy high and outputs frozen through E W, result with done at E(W+1)
  task automatic wait_check(input string nm, input logic [W-1:0] eh, el, input logic ez);
    logic ok_t;
    logic [W-1:0] h0, l0;
    ok_t = 1'b1;
    h0 = hi;
    l0 = lo;
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge clk);
      #1;
      if (k <= W && (busy !== 1'b1 || done !== 1'b0 || hi !== h0 || lo !== l0)) ok_t = 1'b0;
    end
    check({nm, "_timing"}, ok_t, hi, lo, h0, l0);
    check(nm, done === 1'b1 && busy === 1'b0 && div_by_zero === ez && hi === eh && lo === el,
          hi, lo, eh, el);
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] eh, el, ra, rb;
    logic [1:0]   ro;
    logic         ez;
    int           ndone, done_k;
    logic         ok;

    vecs.push_back('{"multu_max", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
    vecs.push_back('{"mult_neg",  2'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
    vecs.push_back('{"div_neg",   2'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{"div_ovf",   2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
    vecs.push_back('{"divu_big",  2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0});
    vecs.push_back('{"divu_1000", 2'd2, 32'd1000,     32'd7,        32'd6,        32'd142,      1'b0});
    vecs.push_back('{"div_zero",  2'd3, 32'hFFFFFF00, 32'd0,        32'hFFFFFF00, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{"div_remneg",2'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0});

    // reset state
    #12;
    check("reset_state", busy === 0 && done === 0 && div_by_zero === 0 && hi === 0 && lo === 0,
          hi, lo, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // table: each request after the first is issued in the previous done cycle
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_check(vecs[i].name, vecs[i].hi, vecs[i].lo, vecs[i].dbz);
    end

    // divide by zero: done/div_by_zero exactly one cycle, result held afterwards
    @(negedge clk);
    issue(2'd2, 32'd100, 32'd0);
    wait_check("divu_zero", 32'h64, 32'hFFFFFFFF, 1'b1);
    @(posedge clk);
    #1;
    check("dbz_one_cycle", done === 0 && div_by_zero === 0 && hi === 32'h64 && lo === 32'hFFFFFFFF,
          hi, lo, 32'h64, 32'hFFFFFFFF);

    // start while busy is ignored
    issue(2'd2, 32'd1000, 32'd7);
    ndone = 0;
    done_k = 0;
    eh = '0;
    el = '0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 10) begin
        start = 1'b1; op = 2'd1; operand_a = 32'd9; operand_b = 32'd11;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        done_k = k;
        eh = hi;
        el = lo;
      end
    end
    check("busy_start_ignored", ndone == 1 && done_k == W + 1 && eh === 32'd6 && el === 32'd142,
          eh, el, 32'd6, 32'd142);

    // async reset mid-operation
    issue(2'd0, 32'd5, 32'd6);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_midop", busy === 0 && done === 0 && div_by_zero === 0 && hi === 0 && lo === 0,
          hi, lo, '0, '0);
    ok = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      if (rst_n === 1'b0 && $time > 0) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    check("no_done_after_reset", ok, hi, lo, '0, '0);
    @(negedge clk);
    issue(2'd0, 32'd5, 32'd6);
    wait_check("multu_after_reset", 32'd0, 32'd30, 1'b0);

    // random ops against the reference model
    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      model(ro, ra, rb, eh, el, ez);
      issue(ro, ra, rb);
      wait_check($sformatf("rand%0d_op%0d_%08h_%08h", n, ro, ra, rb), eh, el, ez);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle integer multiply/divide unit for the processor datapath. It computes 32x32 MULT/MULTU and DIV/DIVU into HI/LO registers. The hi and lo outputs feed the 32-bit 4-input result-select mux directly; the mux's control drives which value reaches writeback. The unit is iterative, one bit per cycle, with a start/busy/done handshake to the pipeline control.

Parameters:
WIDTH, 32, operand width; hi/lo are WIDTH each; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
operand_a  input  WIDTH  multiplicand / dividend.
operand_b  input  WIDTH  multiplier / divisor.
busy  output  1  operation in progress.
done  output  1  one-cycle completion pulse.
div_by_zero  output  1  valid with done; divisor was 0 on a DIV/DIVU.
hi  output  WIDTH  product[63:32] / remainder.
lo  output  WIDTH  product[31:0] / quotient.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset, asserted at any time including mid-operation:
  - state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; internal counter and accumulators cleared.
  - Operation in flight is discarded.
- States:
  - IDLE -> CALC on start=1 at a rising edge. op, operand_a and operand_b are latched at that edge. For signed ops, the absolute values and both sign bits are captured.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. A counter runs 0..WIDTH-1; after the edge with counter=WIDTH-1 the state moves to FIX.
  - FIX: sign correction. Signed product is negated if signs differ. Signed quotient is negated if signs differ. Signed remainder takes the dividend's sign. Results are written to hi/lo and done=1 is registered. State returns to IDLE at the same edge.
- Latency:
  - Start sampled at edge E0 -> hi/lo updated and done=1 after edge E(WIDTH+1), i.e. E33 for the default.
  - Latency is fixed and identical for all ops, including divide-by-zero.
- busy: 1 from the edge after start is sampled until the FIX edge; 0 in the cycle done is high.
- done and div_by_zero are exactly one cycle wide.
- start while busy=1 is ignored: no queuing, no effect on the running op. start in the same cycle as done=1 is accepted (back-to-back).
- Operand or op changes during busy have no effect.
- hi/lo hold their last result until the next completion. They never show intermediate values.
- Divide by zero: hi=operand_a as latched, lo=all ones, div_by_zero=1 with done. No exception; the full latency is still taken.
- Signed divide:
  - Quotient truncates toward zero.
  - Remainder sign follows the dividend; |remainder| < |divisor|.
  - Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, div_by_zero=0.
- Multiply: hi:lo is the full 2*WIDTH-bit result. Two's complement for MULT, unsigned for MULTU.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at E0 -> done=1 after E33 only; hi=0xFFFFFFFE, lo=0x00000001; busy=1 for E1..E32.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then back-to-back DIV a=0xFFFFFFF9 (-7), b=2, with start in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, 33 cycles later.
- DIVU a=100, b=0 -> hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1 for exactly one cycle alongside done.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_by_zero=0. DIVU a=0x80000000, b=0xFFFFFFFF -> lo=0, hi=0x80000000.
- Start DIVU 1000/7; pulse start again with new operands and MULT at cycle 10 -> second start ignored; result hi=6, lo=142 after the original 33 cycles; only one done pulse.
- Start MULTU 5*6; drop rst_n at cycle 15 (async, between edges) -> busy, done, hi and lo are 0 immediately and no done ever appears. After release, new MULTU 5*6 -> lo=30, hi=0.
